// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, parity selectors and parity helper.
// Imported by both the UART receiver and transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Expected parity bit; narrower payloads are zero-extended, which leaves the XOR unchanged.
    function automatic logic parity(input logic [31:0] data, input logic typ);
        return (^data) ^ typ;
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit oversampling counter and 3-sample majority vote for the UART receiver.
// Emits bit_valid_o on the decision cycle and bit_end_o on the last cycle of each bit.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic rx_i,
    input  logic start_i,
    input  logic active_i,
    input  logic clear_i,
    output logic bit_valid_o,
    output logic bit_end_o,
    output logic sampled_bit_o
);

    localparam int unsigned CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] SampleA = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] SampleB = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] Decide  = CW'(OVERSAMPLE / 2 + 1);
    localparam logic [CW-1:0] LastCnt = CW'(OVERSAMPLE - 1);

    logic [CW-1:0] edge_cnt_q, edge_cnt_d;
    logic [1:0]    samp_q, samp_d;

    always_comb begin
        edge_cnt_d = '0;
        samp_d     = samp_q;
        // The start-detect cycle itself counts as edge 0 of the start bit.
        if (start_i) begin
            edge_cnt_d = CW'(1);
        end else if (active_i && !clear_i) begin
            edge_cnt_d = (edge_cnt_q == LastCnt) ? '0 : edge_cnt_q + CW'(1);
        end
        if (active_i && edge_cnt_q == SampleA) samp_d[0] = rx_i;
        if (active_i && edge_cnt_q == SampleB) samp_d[1] = rx_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            edge_cnt_q <= '0;
            samp_q     <= 2'b11;
        end else begin
            edge_cnt_q <= edge_cnt_d;
            samp_q     <= samp_d;
        end
    end

    assign bit_valid_o   = active_i && (edge_cnt_q == Decide);
    assign bit_end_o     = active_i && (edge_cnt_q == LastCnt);
    assign sampled_bit_o = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_i) | (samp_q[1] & rx_i);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start, DATA_WIDTH bits LSB-first, optional parity, one stop bit.
// Define UART_RX_SYNC_EN to insert a 2-flop synchronizer on RX_IN (adds 2 cycles latency).
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = 8,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  DATA_VALID,
    output logic                  PAR_ERR,
    output logic                  STP_ERR,
    output logic                  BUSY
);

    localparam int unsigned BCW = $clog2(DATA_WIDTH + 1);

    logic rx;

`ifdef UART_RX_SYNC_EN
    logic [1:0] sync_q, sync_d;

    assign sync_d = {sync_q[0], RX_IN};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) sync_q <= 2'b11;
        else     sync_q <= sync_d;
    end

    assign rx = sync_q[1];
`else
    assign rx = RX_IN;
`endif

    uart_state_e           state_q, state_d;
    logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  par_bit_q, par_bit_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic                  prev_rx_q, prev_rx_d;
    logic                  valid_q, valid_d;
    logic                  perr_q, perr_d;
    logic                  serr_q, serr_d;
    logic                  start, par_bad;
    logic                  bit_valid, bit_end, sbit;

    uart_rx_sampler #(
        .OVERSAMPLE(OVERSAMPLE)
    ) u_sampler (
        .clk_i        (CLK),
        .rst_i        (RST),
        .rx_i         (rx),
        .start_i      (start),
        .active_i     (state_q != IDLE),
        .clear_i      (state_d == IDLE),
        .bit_valid_o  (bit_valid),
        .bit_end_o    (bit_end),
        .sampled_bit_o(sbit)
    );

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        par_bit_d = par_bit_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        prev_rx_d = rx;
        valid_d   = 1'b0;
        perr_d    = 1'b0;
        serr_d    = 1'b0;
        start     = 1'b0;
        par_bad   = par_en_q && (par_bit_q != parity(32'(shift_q), par_typ_q));

        case (state_q)
            IDLE: begin
                if (prev_rx_q && !rx) begin
                    state_d   = START;
                    start     = 1'b1;
                    par_en_d  = PAR_EN;
                    par_typ_d = PAR_TYP;
                end
            end
            START: begin
                if (bit_valid && sbit) begin
                    state_d = IDLE;
                end else if (bit_end) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (bit_valid) begin
                    shift_d   = {sbit, shift_q[DATA_WIDTH-1:1]};
                    bit_cnt_d = bit_cnt_q + BCW'(1);
                end
                // bit_cnt_d so the check holds even when decision and wrap coincide.
                if (bit_end && bit_cnt_d == BCW'(DATA_WIDTH)) begin
                    state_d = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (bit_valid) par_bit_d = sbit;
                if (bit_end)   state_d   = STOP;
            end
            STOP: begin
                if (bit_valid) begin
                    state_d = IDLE;
                    if (sbit && !par_bad) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        perr_d = par_bad;
                        serr_d = !sbit;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            par_bit_q <= 1'b0;
            par_en_q  <= 1'b0;
            par_typ_q <= PAR_EVEN;
            prev_rx_q <= 1'b1;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            serr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            par_bit_q <= par_bit_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            prev_rx_q <= prev_rx_d;
            valid_q   <= valid_d;
            perr_q    <= perr_d;
            serr_q    <= serr_d;
        end
    end

    assign P_DATA     = data_q;
    assign DATA_VALID = valid_q;
    assign PAR_ERR    = perr_q;
    assign STP_ERR    = serr_q;
    assign BUSY       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: table of single frames plus break, glitch, back-to-back
// and mid-frame reset sequences.
module tb_uart_rx;

    localparam int OS = 8;
`ifdef UART_RX_SYNC_EN
    localparam int LAT_OFF = 2;
`else
    localparam int LAT_OFF = 0;
`endif

    logic       CLK = 1'b0;
    logic       RST;
    logic       RX_IN;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [7:0] P_DATA;
    logic       DATA_VALID;
    logic       PAR_ERR;
    logic       STP_ERR;
    logic       BUSY;

    uart_rx #(
        .OVERSAMPLE(OS),
        .DATA_WIDTH(8)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .RX_IN     (RX_IN),
        .PAR_EN    (PAR_EN),
        .PAR_TYP   (PAR_TYP),
        .P_DATA    (P_DATA),
        .DATA_VALID(DATA_VALID),
        .PAR_ERR   (PAR_ERR),
        .STP_ERR   (STP_ERR),
        .BUSY      (BUSY)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Cumulative event monitor, sampled on the falling edge.
    int         n_valid = 0;
    int         n_perr  = 0;
    int         n_serr  = 0;
    int         last_evt = -1;
    logic [7:0] vdata [64];

    always @(negedge CLK) begin
        if (DATA_VALID) begin
            vdata[n_valid % 64] <= P_DATA;
            n_valid <= n_valid + 1;
        end
        if (PAR_ERR) n_perr <= n_perr + 1;
        if (STP_ERR) n_serr <= n_serr + 1;
        if (DATA_VALID || PAR_ERR || STP_ERR) last_evt <= cyc;
    end

    int n_vec = 0;
    int n_bad = 0;
    int t0 = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic idle(input int n);
        RX_IN = 1'b1;
        repeat (n) @(negedge CLK);
    endtask

    // Drives one frame cycle by cycle. glitch_bit inverts data bit N for one cycle at mid-bit;
    // abort_at asserts RST at that frame cycle and returns.
    task automatic send_frame(input logic [7:0] d, input logic pe, input logic pt,
                              input logic pbit, input logic stopb, input int stop_len,
                              input int glitch_bit, input int abort_at);
        logic [10:0] bits;
        int nb;
        int len;
        int k;
        bits      = '1;
        bits[0]   = 1'b0;
        bits[8:1] = d;
        if (pe) begin
            bits[9]  = pbit;
            bits[10] = stopb;
            nb = 11;
        end else begin
            bits[9] = stopb;
            nb = 10;
        end
        PAR_EN  = pe;
        PAR_TYP = pt;
        for (int i = 0; i < nb; i++) begin
            len = (i == nb - 1) ? stop_len : OS;
            for (int e = 0; e < len; e++) begin
                @(posedge CLK);
                #1;
                k = i * OS + e;
                if (k == abort_at) begin
                    RST = 1'b1;
                    return;
                end
                RX_IN = bits[i] ^ ((i == glitch_bit + 1) && (e == OS / 2));
                if (k == 0) t0 = cyc;
                // Flip the config after it has been latched; the frame must be unaffected.
                if (k == 4) begin
                    PAR_EN  = !pe;
                    PAR_TYP = !pt;
                end
            end
        end
    endtask

    typedef struct {
        logic [7:0] data;
        logic       pe;
        logic       pt;
        logic       pbit;
        logic       stopb;
        int         ev;
        int         ep;
        int         es;
        logic [7:0] epd;
        int         lat;
    } vec_t;

    vec_t vecs [8];

    int nv, np, ns;
    logic busy_seen;

    initial begin
        vecs[0] = '{8'hAA, 1'b1, 1'b0, 1'b0, 1'b1, 1, 0, 0, 8'hAA, 86};
        vecs[1] = '{8'hAA, 1'b1, 1'b0, 1'b1, 1'b1, 0, 1, 0, 8'hAA, 86};
        vecs[2] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1, 8'hAA, 78};
        vecs[3] = '{8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1, 0, 0, 8'h55, 78};
        vecs[4] = '{8'h07, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1, 1, 8'h55, 86};
        vecs[5] = '{8'h80, 1'b1, 1'b1, 1'b0, 1'b1, 1, 0, 0, 8'h80, 86};
        vecs[6] = '{8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1, 8'h80, 86};
        vecs[7] = '{8'h01, 1'b1, 1'b1, 1'b0, 1'b1, 1, 0, 0, 8'h01, 86};

        RST = 1'b1; RX_IN = 1'b1; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_pdata", int'(P_DATA), 0);
        chk("rst_valid", int'(DATA_VALID), 0);
        chk("rst_perr", int'(PAR_ERR), 0);
        chk("rst_serr", int'(STP_ERR), 0);
        chk("rst_busy", int'(BUSY), 0);
        RST = 1'b0;
        idle(5);

        for (int v = 0; v < 8; v++) begin
            nv = n_valid; np = n_perr; ns = n_serr;
            send_frame(vecs[v].data, vecs[v].pe, vecs[v].pt, vecs[v].pbit, vecs[v].stopb,
                       OS, -1, -1);
            idle(20);
            chk($sformatf("v%0d_valid", v), n_valid - nv, vecs[v].ev);
            chk($sformatf("v%0d_perr", v), n_perr - np, vecs[v].ep);
            chk($sformatf("v%0d_serr", v), n_serr - ns, vecs[v].es);
            chk($sformatf("v%0d_pdata", v), int'(P_DATA), int'(vecs[v].epd));
            chk($sformatf("v%0d_latency", v), last_evt - t0, vecs[v].lat + LAT_OFF);
            chk($sformatf("v%0d_busy", v), int'(BUSY), 0);
        end

        // Break: stop bit low and line held low afterwards.
        nv = n_valid; np = n_perr; ns = n_serr;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, OS, -1, -1);
        busy_seen = 1'b0;
        repeat (200) begin
            @(negedge CLK);
            if (BUSY) busy_seen = 1'b1;
        end
        chk("brk_serr", n_serr - ns, 1);
        chk("brk_latency", last_evt - t0, 78 + LAT_OFF);
        chk("brk_valid", n_valid - nv, 0);
        chk("brk_perr", n_perr - np, 0);
        chk("brk_busy_seen", int'(busy_seen), 0);
        idle(20);
        chk("brk_rearm_quiet", (n_valid - nv) + (n_serr - ns) + (n_perr - np), 1);

        // Two-cycle low pulse is a false start.
        nv = n_valid; ns = n_serr;
        @(posedge CLK); #1; RX_IN = 1'b0; t0 = cyc;
        @(posedge CLK); #1;
        @(posedge CLK); #1; RX_IN = 1'b1;
        while (cyc < t0 + 3 + LAT_OFF) @(negedge CLK);
        chk("glitch_busy_hi", int'(BUSY), 1);
        while (cyc < t0 + 6 + LAT_OFF) @(negedge CLK);
        chk("glitch_busy_lo", int'(BUSY), 0);
        idle(100);
        chk("glitch_no_out", (n_valid - nv) + (n_serr - ns), 0);
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, OS, -1, -1);
        idle(20);
        chk("glitch_next_valid", n_valid - nv, 1);
        chk("glitch_next_pdata", int'(P_DATA), 8'h55);

        // Back-to-back odd-parity frames; second carries a mid-bit single-cycle glitch.
        nv = n_valid; np = n_perr; ns = n_serr;
        send_frame(8'h01, 1'b1, 1'b1, 1'b0, 1'b1, OS / 2 + 2, -1, -1);
        send_frame(8'hFF, 1'b1, 1'b1, 1'b1, 1'b1, OS, 3, -1);
        idle(20);
        chk("b2b_valid", n_valid - nv, 2);
        chk("b2b_data0", int'(vdata[nv % 64]), 8'h01);
        chk("b2b_data1", int'(vdata[(nv + 1) % 64]), 8'hFF);
        chk("b2b_perr", n_perr - np, 0);
        chk("b2b_serr", n_serr - ns, 0);

        // Reset in the middle of a frame.
        nv = n_valid; np = n_perr; ns = n_serr;
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, OS, -1, 40);
        #1;
        chk("mrst_pdata", int'(P_DATA), 0);
        chk("mrst_valid", int'(DATA_VALID), 0);
        chk("mrst_perr", int'(PAR_ERR), 0);
        chk("mrst_serr", int'(STP_ERR), 0);
        chk("mrst_busy", int'(BUSY), 0);
        RX_IN = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        idle(5);
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, OS, -1, -1);
        idle(20);
        chk("mrst_next_valid", n_valid - nv, 1);
        chk("mrst_next_pdata", int'(P_DATA), 8'hA5);
        chk("mrst_next_err", (n_perr - np) + (n_serr - ns), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Serial UART receiver that sits directly downstream of the team's UART transmitter and shares its frame format. Frame is: start (0), 8 data bits LSB-first, optional parity, 1 stop (1). The line is oversampled OVERSAMPLE clocks per bit, and each bit is resolved by a 3-sample majority vote around mid-bit. Received bytes go to the parallel side with a one-cycle valid pulse and error flags; the TX loopback bench uses this block as its checker.

Parameters:
OVERSAMPLE, 8, clock cycles per serial bit; legal values are even and ≥4.
DATA_WIDTH, 8, payload bits per frame.

Ports:
CLK  in  1  system clock; the single clock domain.
RST  in  1  asynchronous, active-high reset.
RX_IN  in  1  serial line; idles high.
PAR_EN  in  1  1 = frame carries a parity bit.
PAR_TYP  in  1  0 = even parity, 1 = odd parity.
P_DATA  out  DATA_WIDTH  last received payload.
DATA_VALID  out  1  one-cycle pulse; P_DATA is good.
PAR_ERR  out  1  one-cycle pulse; parity mismatch.
STP_ERR  out  1  one-cycle pulse; stop bit sampled 0.
BUSY  out  1  high while a frame is being received.

Behaviour:
- Reset and clocking:
  - One clock; RST is asynchronous and active-high.
  - Reset values: P_DATA=0, DATA_VALID=0, PAR_ERR=0, STP_ERR=0, BUSY=0. State=IDLE, counters=0, prev_rx=1.
- Counters:
  - edge_cnt runs 0..OVERSAMPLE-1 within each bit.
  - bit_cnt indexes the bit within the frame.
- Sampling:
  - Samples are taken at edge_cnt = OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1.
  - The bit value is the majority of those 3 samples, resolved at edge_cnt = OVERSAMPLE/2+1 (the "decision cycle").
- States and transitions:
  - IDLE: when prev_rx=1 and rx=0, go to START with edge_cnt=0 in that cycle. PAR_EN and PAR_TYP are latched at this point; changes mid-frame are ignored.
  - START: at the decision cycle, a bit of 1 is a glitch and returns to IDLE with no outputs. At edge_cnt wrap, go to DATA.
  - DATA: shift bits in LSB-first. After DATA_WIDTH bits, go to PARITY if the latched PAR_EN=1, else go to STOP.
  - PARITY: compare the sampled bit against the XOR of the data bits, inverted when PAR_TYP=1.
  - STOP: at the decision cycle, evaluate the frame and return to IDLE immediately; the remaining half stop bit is ignored.
- STOP-cycle outputs, registered and visible the cycle after the decision:
  - stop=1 and parity ok (or parity disabled): P_DATA updates, DATA_VALID=1.
  - stop=1 and parity bad: PAR_ERR=1, P_DATA unchanged, no DATA_VALID.
  - stop=0: STP_ERR=1, plus PAR_ERR if parity is also bad. P_DATA unchanged, no DATA_VALID.
- Latency, counting the first low sample as cycle 0:
  - Outputs appear at cycle (nbits-1)*OVERSAMPLE + OVERSAMPLE/2+2, where nbits = 10 + PAR_EN.
  - OVERSAMPLE=8: cycle 86 with parity, cycle 78 without.
- BUSY: high from the cycle after start detection until the cycle after the STOP decision.
- Break / line held low: after STP_ERR the block stays in IDLE. Because prev_rx=0, it does not re-arm until the line has returned high.
- Back-to-back frames: a falling edge in the cycle right after the STOP decision is detected normally.
- RST mid-frame: immediate abort to reset values; no partial outputs.

Optional Feature:
UART_RX_SYNC_EN
- Defined: RX_IN passes through a 2-flop synchronizer, reset value 1, before all logic. Every latency figure above grows by 2 cycles.
- Undefined: RX_IN feeds the logic directly; the source must already be synchronous to CLK.

Decomposition:
- Package uart_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP);
  - constants PAR_EVEN=0 and PAR_ODD=1;
  - a parity function, parity(data, typ).
- The TX block imports the same package.
- One natural sub-module, uart_rx_sampler: owns edge_cnt and the majority vote, and outputs a bit_valid strobe plus the sampled bit.

Test Plan:
1. OVERSAMPLE=8, PAR_EN=1, PAR_TYP=0, frame 0xAA with parity bit 0 → P_DATA=0xAA, DATA_VALID pulse at cycle 86, PAR_ERR=0, STP_ERR=0.
2. Same frame with parity bit 1 → PAR_ERR pulse at cycle 86, no DATA_VALID, P_DATA holds its previous value.
3. PAR_EN=0, frame 0x3C with stop bit driven 0 → STP_ERR at cycle 78. Holding RX_IN low for 200 cycles gives no further outputs, and BUSY stays 0 after the error.
4. RX_IN low for 2 cycles only → no DATA_VALID, BUSY returns to 0 by cycle 6. A valid frame 0x55 then received normally → P_DATA=0x55.
5. Back-to-back frames 0x01, 0xFF with PAR_TYP=1 (odd) → two DATA_VALID pulses, P_DATA=0x01 then 0xFF, no errors. A single-cycle glitch at a mid-bit sample is rejected by the majority vote.
6. RST asserted at cycle 40 of a frame → all outputs 0 immediately. The next full frame 0xA5 is received correctly.
